reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//  Round-robin arbiter for the single register-file write port.
//  NUM_REQ requesters (ALU result, MDR load, LO/HI move, I/O in) each present a
//  4-bit register index and a data word. One winner is granted per cycle.
//  The winner's index is decoded to a one-hot 16-bit register-enable (R0in..R15in),
//  and its data is driven to the register-file write bus.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8)
//  DATA_W    32  write-data width
//  IDX_W     4   register-index width (16 registers)
// PORTS
//  in_clk       in   1               clock, all state on rising edge
//  in_reset_n   in   1               asynchronous, active-low reset
//  in_req       in   NUM_REQ         per-requester write request (level)
//  in_idx       in   NUM_REQ*IDX_W   packed target indices, requester k at [k*IDX_W +: IDX_W]
//  in_data      in   NUM_REQ*DATA_W  packed write data, same packing
//  in_stall     in   1               datapath hold; no new grant is issued while high
//  out_grant    out  NUM_REQ         one-hot grant, 1-cycle pulse
//  out_reg_en   out  16              one-hot register write enable, 0 when idle
//  out_wr_data  out  DATA_W          write data of the granted requester, 0 when idle
//  out_busy     out  1               1 while any in_req is pending and not granted this cycle
// BEHAVIOUR
//  - Reset (async assert, sync deassert by caller): out_grant=0, out_reg_en=0,
//    out_wr_data=0, out_busy=0, rr_ptr=0, state=IDLE.
//  - Arbitration: sample in_req at edge N, then present the registered result during cycle N+1.
//    The register file writes on the edge that ends cycle N+1. Grant latency is 1 cycle.
//  - Eligible set = in_req & ~out_grant. The requester granted this cycle is masked,
//    so it is never granted two cycles in a row by a stale req.
//  - Winner = first eligible requester scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    After a grant to k, rr_ptr <= (k+1) mod NUM_REQ. With no grant, rr_ptr holds.
//  - Handshake: the requester holds req, idx and data stable until it sees its grant bit.
//    It may drop req in the grant cycle. A req dropped before grant is simply withdrawn.
//  - FSM: IDLE -> GRANT when the eligible set is non-empty and in_stall=0.
//    GRANT -> GRANT on the same condition, otherwise GRANT -> IDLE.
//    IDLE holds while the eligible set is empty or in_stall=1.
//    In IDLE, all outputs except out_busy are 0.
//  - Stall: in_stall=1 at an edge gives no grant next cycle. A grant already presented
//    in the current cycle completes normally.
//  - out_busy (combinational) = |(in_req & ~out_grant).
//  - Index decode: out_reg_en = 1 << idx_winner. Exactly one bit set in GRANT.
//  - Simultaneous same-index requests are not merged. They are serialized in RR order,
//    and the last write wins.
//  - Reset mid-grant: outputs clear immediately. Pending requests re-arbitrate from
//    rr_ptr=0 after reset release.
// CONFIGURATION
//  - REG_ZERO_PROTECT_EN defined: a grant to idx 0 still pulses out_grant, but
//    out_reg_en=0 and out_wr_data=0 (R0 is read-only).
//  - Not defined: idx 0 is written like any other register (out_reg_en=16'h0001).
// STRUCTURE
//  - Shared package mini_src_pkg: REG_IDX_W=4, NUM_REGS=16, WORD_W=32,
//    and the arb_state_t enum {ARB_IDLE, ARB_GRANT}.
//  - Sub-module rr_pick: combinational round-robin picker (eligible, ptr -> one-hot winner, valid).
//  - Top level holds the FSM, rr_ptr, the output registers, decode and data mux.
// TESTING
//  1 Reset: hold in_reset_n=0 with in_req=4'b1111.
//    -> all outputs 0. Release -> grant 4'b0001 one cycle later.
//  2 Single req: req1, idx=5, data=32'hDEADBEEF.
//    -> next cycle out_grant=4'b0010, out_reg_en=16'h0020, out_wr_data=32'hDEADBEEF.
//  3 Fairness: in_req=4'b1111 held for 8 cycles.
//    -> grants 0001,0010,0100,1000,0001,... with no gaps and no repeats.
//  4 Stall: in_req=4'b0100, in_stall=1 for 3 cycles.
//    -> out_grant=0 and out_busy=1 throughout. Stall low -> grant 4'b0100 next cycle.
//  5 R0 write: req0 with idx=0. With REG_ZERO_PROTECT_EN: out_grant=4'b0001, out_reg_en=0.
//    Without: out_reg_en=16'h0001.
//  6 Reset mid-grant: assert in_reset_n=0 during a GRANT cycle
//    -> outputs clear the same cycle, rr_ptr=0.

Source files
------------

// File: rtl/mini_src_pkg.sv
// Shared datapath constants and the write-arbiter state type.
package mini_src_pkg;

    localparam int REG_IDX_W = 4;
    localparam int NUM_REGS  = 16;
    localparam int WORD_W    = 32;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of i_elig scanning upward
// from i_ptr with wrap-around; returns one-hot winner, its index and a valid flag.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_elig,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_win_oh,
    output logic [PTR_W-1:0] o_win_idx,
    output logic             o_valid
);

    int               w_pos;
    logic [PTR_W-1:0] w_cand;

    always_comb begin
        o_win_oh  = '0;
        o_win_idx = '0;
        o_valid   = 1'b0;
        w_pos     = 0;
        w_cand    = '0;
        for (int i = 0; i < N; i++) begin
            w_pos  = (int'(i_ptr) + i) % N;
            w_cand = PTR_W'(w_pos);
            if (!o_valid && i_elig[w_cand]) begin
                o_valid          = 1'b1;
                o_win_oh[w_cand] = 1'b1;
                o_win_idx        = w_cand;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with registered
// one-hot grant, register-enable decode and data mux. Optional macro: REG_ZERO_PROTECT_EN.
module reg_write_arbiter
    import mini_src_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = WORD_W,
    parameter int IDX_W   = REG_IDX_W
) (
    input  logic                      in_clk,
    input  logic                      in_reset_n,
    input  logic [NUM_REQ-1:0]        in_req,
    input  logic [NUM_REQ*IDX_W-1:0]  in_idx,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    input  logic                      in_stall,
    output logic [NUM_REQ-1:0]        out_grant,
    output logic [NUM_REGS-1:0]       out_reg_en,
    output logic [DATA_W-1:0]         out_wr_data,
    output logic                      out_busy,
    output arb_state_t                out_dbg_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t          r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REGS-1:0] r_reg_en;
    logic [DATA_W-1:0]   r_wr_data;

    arb_state_t          w_state_nxt;
    logic [PTR_W-1:0]    w_ptr_nxt;
    logic [NUM_REQ-1:0]  w_grant_nxt;
    logic [NUM_REGS-1:0] w_reg_en_nxt;
    logic [DATA_W-1:0]   w_wr_data_nxt;
    logic [NUM_REQ-1:0]  w_elig;
    logic [NUM_REQ-1:0]  w_win_oh;
    logic [PTR_W-1:0]    w_win_idx;
    logic                w_win_valid;
    logic                w_go;
    logic [IDX_W-1:0]    w_win_reg_idx;
    logic [DATA_W-1:0]   w_win_data;

    // The requester presented this cycle is masked so a stale req cannot win twice in a row.
    assign w_elig        = in_req & ~r_grant;
    assign w_go          = w_win_valid & ~in_stall;
    assign w_win_reg_idx = in_idx[w_win_idx*IDX_W +: IDX_W];
    assign w_win_data    = in_data[w_win_idx*DATA_W +: DATA_W];

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_elig    (w_elig),
        .i_ptr     (r_ptr),
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx),
        .o_valid   (w_win_valid)
    );

    always_comb begin
        w_state_nxt   = ARB_IDLE;
        w_ptr_nxt     = r_ptr;
        w_grant_nxt   = '0;
        w_reg_en_nxt  = '0;
        w_wr_data_nxt = '0;
        case (r_state)
            ARB_IDLE:  w_state_nxt = w_go ? ARB_GRANT : ARB_IDLE;
            ARB_GRANT: w_state_nxt = w_go ? ARB_GRANT : ARB_IDLE;
            default:   w_state_nxt = ARB_IDLE;
        endcase
        if (w_state_nxt == ARB_GRANT) begin
            w_grant_nxt   = w_win_oh;
            w_ptr_nxt     = (w_win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
            w_reg_en_nxt  = NUM_REGS'(1) << w_win_reg_idx;
            w_wr_data_nxt = w_win_data;
`ifdef REG_ZERO_PROTECT_EN
            // R0 is read-only: the grant still retires the request, but nothing is written.
            if (w_win_reg_idx == '0) begin
                w_reg_en_nxt  = '0;
                w_wr_data_nxt = '0;
            end
`else
`endif
        end
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_state   <= ARB_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_reg_en  <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_grant   <= w_grant_nxt;
            r_reg_en  <= w_reg_en_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    assign out_grant     = r_grant;
    assign out_reg_en    = r_reg_en;
    assign out_wr_data   = r_wr_data;
    assign out_dbg_state = r_state;
    // Held low during reset so every output reads 0 while in_reset_n is asserted.
    assign out_busy      = in_reset_n & (|(in_req & ~r_grant));

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus randomized
// requesters obeying the req/grant handshake, checked against a behavioural model.
module tb_reg_write_arbiter;
    import mini_src_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*IW-1:0]   idx;
    logic [N*DW-1:0]   data;
    logic              stall;
    logic [N-1:0]      grant;
    logic [15:0]       reg_en;
    logic [DW-1:0]     wr_data;
    logic              busy;
    arb_state_t        dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: last expected grant, rotating priority start, expected write data.
    logic [N-1:0]  exp_grant;
    logic [15:0]   exp_reg_en;
    int            m_ptr;
    logic [DW-1:0] exp_q[$];

    logic          zero_protect;
    logic [N-1:0]  prev_grant;

    reg_write_arbiter dut (
        .in_clk        (clk),
        .in_reset_n    (rst_n),
        .in_req        (req),
        .in_idx        (idx),
        .in_data       (data),
        .in_stall      (stall),
        .out_grant     (grant),
        .out_reg_en    (reg_en),
        .out_wr_data   (wr_data),
        .out_busy      (busy),
        .out_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [IW-1:0] i, input logic [DW-1:0] d);
        req[k]             = 1'b1;
        idx[k*IW +: IW]    = i;
        data[k*DW +: DW]   = d;
    endtask

    // Applies the arbitration rules to the inputs sampled at this edge.
    task automatic model_edge();
        logic [N-1:0]  elig;
        logic [IW-1:0] r;
        logic [DW-1:0] d;
        logic          found;
        int            k;
        elig       = req & ~exp_grant;
        exp_grant  = '0;
        exp_reg_en = '0;
        d          = '0;
        found      = 1'b0;
        if (!stall) begin
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (!found && elig[k]) begin
                    found        = 1'b1;
                    exp_grant[k] = 1'b1;
                    r            = idx[k*IW +: IW];
                    d            = data[k*DW +: DW];
                    exp_reg_en   = 16'h0001 << r;
                    if (zero_protect && r == 0) begin
                        exp_reg_en = '0;
                        d          = '0;
                    end
                    m_ptr = (k + 1) % N;
                end
            end
        end
        exp_q.push_back(d);
    endtask

    // Entered and left at a falling edge with the inputs for the coming edge already set.
    task automatic tick();
        #1;
        check_eq("busy", busy, (rst_n && ((req & ~exp_grant) != 0)) ? 1 : 0);
        @(posedge clk);
        model_edge();
        #1;
        check_eq("grant", grant, exp_grant);
        check_eq("reg_en", reg_en, exp_reg_en);
        check_eq("wr_data", wr_data, exp_q.pop_front());
        check_eq("state", dbg_state, (exp_grant != 0) ? ARB_GRANT : ARB_IDLE);
        @(negedge clk);
    endtask

    initial begin
`ifdef REG_ZERO_PROTECT_EN
        zero_protect = 1'b1;
`else
        zero_protect = 1'b0;
`endif
        rst_n      = 1'b0;
        req        = '0;
        idx        = '0;
        data       = '0;
        stall      = 1'b0;
        exp_grant  = '0;
        exp_reg_en = '0;
        m_ptr      = 0;

        // Reset with all requesters pending
        for (int k = 0; k < N; k++) set_req(k, IW'(k + 1), DW'(32'h1000 + k));
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_grant", grant, 0);
        check_eq("rst_reg_en", reg_en, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_state", dbg_state, ARB_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("t1_first_grant", grant, 4'b0001);
        req = '0;
        tick();

        // Single requester
        set_req(1, 4'd5, 32'hDEADBEEF);
        tick();
        check_eq("t2_grant", grant, 4'b0010);
        check_eq("t2_reg_en", reg_en, 16'h0020);
        check_eq("t2_wr_data", wr_data, 32'hDEADBEEF);
        req = '0;
        tick();

        // Fairness under full load
        for (int k = 0; k < N; k++) set_req(k, IW'(k + 8), DW'(32'hA0 + k));
        prev_grant = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("t3_onehot", $onehot(grant) ? 1 : 0, 1);
            if (i > 0) check_eq("t3_rotate", grant, {prev_grant[N-2:0], prev_grant[N-1]});
            prev_grant = grant;
        end
        req = '0;
        tick();

        // Stall holds off the grant
        set_req(2, 4'd3, 32'h5555AAAA);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t4_stall_grant", grant, 0);
            check_eq("t4_stall_busy", busy, 1);
        end
        stall = 1'b0;
        tick();
        check_eq("t4_release_grant", grant, 4'b0100);
        req = '0;
        tick();

        // Write to R0
        set_req(0, 4'd0, 32'hCAFEF00D);
        tick();
        check_eq("t5_grant", grant, 4'b0001);
        check_eq("t5_reg_en", reg_en, zero_protect ? 16'h0000 : 16'h0001);
        check_eq("t5_wr_data", wr_data, zero_protect ? 32'h0 : 32'hCAFEF00D);
        req = '0;
        tick();

        // Reset during a grant cycle
        for (int k = 0; k < N; k++) set_req(k, IW'(k + 4), DW'(32'hB0 + k));
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("t6_grant", grant, 0);
        check_eq("t6_reg_en", reg_en, 0);
        check_eq("t6_wr_data", wr_data, 0);
        check_eq("t6_busy", busy, 0);
        exp_grant = '0;
        m_ptr     = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("t6_regrant", grant, 4'b0001);
        req = '0;
        tick();

        // Randomized requesters with handshake and occasional stall
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 4) == 0);
            tick();
            for (int k = 0; k < N; k++) begin
                if (grant[k]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(k, IW'($urandom_range(0, 15)), DW'($urandom));
                    else
                        req[k] = 1'b0;
                end else if (req[k]) begin
                    if ($urandom_range(0, 15) == 0) req[k] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(k, IW'($urandom_range(0, 15)), DW'($urandom));
                end
            end
        end
        req   = '0;
        stall = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
